// File: rtl/vid_timing_rx.sv
// rtl/vid_timing_rx.sv - display stream monitor: frame geometry, mode decode, lock and timing-error flags
// Optional pixel checksum (FRAME_SUM) is built only when VID_RX_SUM_EN is defined.
module vid_timing_rx #(
  parameter int HW     = 12,
  parameter int VW     = 11,
  parameter int LOCK_N = 2,
  parameter int VGA_HT = 800,
  parameter int VGA_HA = 640,
  parameter int VGA_VT = 525,
  parameter int VGA_VA = 480,
  parameter int XGA_HT = 1344,
  parameter int XGA_HA = 1024,
  parameter int XGA_VT = 806,
  parameter int XGA_VA = 768
) (
  input  logic          DCLK,
  input  logic          RST_X,
  input  logic          VID_HSYNC_X,
  input  logic          VID_VSYNC_X,
  input  logic          VID_DE,
  input  logic [7:0]    VID_R,
  input  logic [7:0]    VID_G,
  input  logic [7:0]    VID_B,
  output logic [HW-1:0] H_TOTAL,
  output logic [HW-1:0] H_ACTIVE,
  output logic [VW-1:0] V_TOTAL,
  output logic [VW-1:0] V_ACTIVE,
  output logic [1:0]    MODE,
  output logic          LOCKED,
  output logic          FRAME_DONE,
  output logic          TIMING_ERR,
  output logic [23:0]   FRAME_SUM
);

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCK} state_t;

  localparam logic [HW-1:0] HMAX    = {HW{1'b1}};
  localparam logic [VW-1:0] VMAX    = {VW{1'b1}};
  localparam logic [7:0]    LOCK_M1 = 8'(LOCK_N - 1);

  state_t        state, state_nxt;
  logic          hs1, hs2, vs1, vs2, de1;
  logic          hfall, vfall, run;
  logic [HW-1:0] hcnt, decnt, de_ref, hcap;
  logic [VW-1:0] vcnt, vact;
  logic          de_ref_v, de_bad, sat, hcap_v, prev_good;
  logic          line_de, sat_now;
  logic [HW-1:0] fin_ht, fin_ha;
  logic [VW-1:0] fin_vt, fin_va;
  logic          fin_good, same;
  logic [1:0]    fin_mode;
  logic [7:0]    match, match_nxt, match_inc;
  logic          locked_nxt, terr_nxt, fdone_nxt, latch;

  function automatic logic [HW-1:0] hinc(input logic [HW-1:0] v);
    return (v == HMAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [VW-1:0] vinc(input logic [VW-1:0] v);
    return (v == VMAX) ? v : v + 1'b1;
  endfunction

  // Sync regs reset low so a sync held low across reset never reads as a fall.
  always_ff @(posedge DCLK or negedge RST_X) begin
    if (!RST_X) begin
      hs1 <= 1'b0;
      hs2 <= 1'b0;
      vs1 <= 1'b0;
      vs2 <= 1'b0;
      de1 <= 1'b0;
    end else begin
      hs1 <= VID_HSYNC_X;
      hs2 <= hs1;
      vs1 <= VID_VSYNC_X;
      vs2 <= vs1;
      de1 <= VID_DE;
    end
  end

  assign hfall = hs2 & ~hs1;
  assign vfall = vs2 & ~vs1;
  assign run   = (state != S_SEARCH) | vfall;

  assign line_de = (decnt != '0);
  assign sat_now = (hcnt == HMAX) | (decnt == HMAX) | (vcnt == VMAX) | (vact == VMAX);

  always_ff @(posedge DCLK or negedge RST_X) begin
    if (!RST_X) begin
      hcnt     <= '0;
      decnt    <= '0;
      vcnt     <= '0;
      vact     <= '0;
      de_ref   <= '0;
      de_ref_v <= 1'b0;
      de_bad   <= 1'b0;
      sat      <= 1'b0;
      hcap     <= '0;
      hcap_v   <= 1'b0;
    end else if (!run) begin
      hcnt     <= '0;
      decnt    <= '0;
      vcnt     <= '0;
      vact     <= '0;
      de_ref   <= '0;
      de_ref_v <= 1'b0;
      de_bad   <= 1'b0;
      sat      <= 1'b0;
      hcap     <= '0;
      hcap_v   <= 1'b0;
    end else begin
      hcnt <= hfall ? HW'(1) : hinc(hcnt);
      if (hfall || vfall)
        decnt <= {{(HW-1){1'b0}}, de1};
      else if (de1)
        decnt <= hinc(decnt);
      // The closing frame is evaluated combinationally; here the new frame starts at line 0.
      if (vfall) begin
        vcnt     <= {{(VW-1){1'b0}}, hfall};
        vact     <= '0;
        de_ref   <= '0;
        de_ref_v <= 1'b0;
        de_bad   <= 1'b0;
        sat      <= 1'b0;
        hcap     <= '0;
        hcap_v   <= 1'b0;
      end else begin
        sat <= sat | sat_now;
        if (hfall) begin
          vcnt <= vinc(vcnt);
          if (!hcap_v) begin
            hcap   <= hcnt;
            hcap_v <= 1'b1;
          end
          if (line_de) begin
            vact <= vinc(vact);
            if (!de_ref_v) begin
              de_ref   <= decnt;
              de_ref_v <= 1'b1;
            end else if (decnt != de_ref) begin
              de_bad <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Closing-frame view: folds in the line still open when VSYNC falls.
  assign fin_ht   = hcap_v ? hcap : hcnt;
  assign fin_ha   = de_ref_v ? de_ref : decnt;
  assign fin_vt   = vcnt;
  assign fin_va   = line_de ? vinc(vact) : vact;
  assign fin_good = ~(sat | sat_now) & ~de_bad & ~(line_de & de_ref_v & (decnt != de_ref));
  assign same     = fin_good & prev_good & (fin_ht == H_TOTAL) & (fin_ha == H_ACTIVE) &
                    (fin_vt == V_TOTAL) & (fin_va == V_ACTIVE);

  always_comb begin
    fin_mode = 2'b00;
    if (fin_good && fin_ht == HW'(VGA_HT) && fin_ha == HW'(VGA_HA) &&
        fin_vt == VW'(VGA_VT) && fin_va == VW'(VGA_VA))
      fin_mode = 2'b01;
    else if (fin_good && fin_ht == HW'(XGA_HT) && fin_ha == HW'(XGA_HA) &&
             fin_vt == VW'(XGA_VT) && fin_va == VW'(XGA_VA))
      fin_mode = 2'b10;
  end

  assign match_inc = match + 8'd1;

  always_comb begin
    state_nxt  = state;
    match_nxt  = match;
    locked_nxt = LOCKED;
    terr_nxt   = TIMING_ERR;
    fdone_nxt  = 1'b0;
    latch      = 1'b0;
    case (state)
      S_SEARCH: begin
        if (vfall) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (vfall) begin
          latch     = 1'b1;
          fdone_nxt = 1'b1;
          if (same) begin
            match_nxt = match_inc;
            if (match_inc >= LOCK_M1) begin
              state_nxt  = S_LOCK;
              locked_nxt = 1'b1;
            end
          end else begin
            match_nxt = '0;
          end
        end
      end
      S_LOCK: begin
        if (vfall) begin
          latch     = 1'b1;
          fdone_nxt = 1'b1;
          if (!same) begin
            terr_nxt   = 1'b1;
            locked_nxt = 1'b0;
            match_nxt  = '0;
            state_nxt  = S_MEASURE;
          end
        end
      end
      default: state_nxt = S_SEARCH;
    endcase
  end

  always_ff @(posedge DCLK or negedge RST_X) begin
    if (!RST_X) begin
      state      <= S_SEARCH;
      match      <= '0;
      LOCKED     <= 1'b0;
      TIMING_ERR <= 1'b0;
      FRAME_DONE <= 1'b0;
      H_TOTAL    <= '0;
      H_ACTIVE   <= '0;
      V_TOTAL    <= '0;
      V_ACTIVE   <= '0;
      MODE       <= 2'b00;
      prev_good  <= 1'b0;
    end else begin
      state      <= state_nxt;
      match      <= match_nxt;
      LOCKED     <= locked_nxt;
      TIMING_ERR <= terr_nxt;
      FRAME_DONE <= fdone_nxt;
      if (latch) begin
        H_TOTAL   <= fin_ht;
        H_ACTIVE  <= fin_ha;
        V_TOTAL   <= fin_vt;
        V_ACTIVE  <= fin_va;
        MODE      <= fin_mode;
        prev_good <= fin_good;
      end
    end
  end

`ifdef VID_RX_SUM_EN
  logic [23:0] rgb1, sum_acc;

  always_ff @(posedge DCLK or negedge RST_X) begin
    if (!RST_X) begin
      rgb1      <= '0;
      sum_acc   <= '0;
      FRAME_SUM <= '0;
    end else begin
      rgb1 <= {VID_R, VID_G, VID_B};
      if (!run)
        sum_acc <= '0;
      else if (vfall)
        sum_acc <= de1 ? rgb1 : 24'h0;
      else if (de1)
        sum_acc <= sum_acc + rgb1;
      if (latch) FRAME_SUM <= sum_acc;
    end
  end
`else
  logic unused_rgb;
  assign unused_rgb = ^{VID_R, VID_G, VID_B};
  assign FRAME_SUM  = 24'h0;
`endif

endmodule

// File: tb/tb_vid_timing_rx.sv
// tb/tb_vid_timing_rx.sv - directed scoreboard bench for vid_timing_rx using scaled VGA/XGA geometries
module tb_vid_timing_rx;

  localparam int V_HT = 50, V_HA = 40, V_VT = 21, V_VA = 16;
  localparam int X_HT = 64, X_HA = 48, X_VT = 30, X_VA = 24;
  localparam logic [23:0] V_RGB = 24'h0000FF;
  localparam logic [23:0] X_RGB = 24'h102030;

  typedef struct {
    int          ht, ha, vt, va, mode, lk, er;
    logic [31:0] sum;
  } exp_t;

  logic        DCLK = 1'b0;
  logic        RST_X, VID_HSYNC_X, VID_VSYNC_X, VID_DE;
  logic [7:0]  VID_R, VID_G, VID_B;
  logic [11:0] H_TOTAL, H_ACTIVE;
  logic [10:0] V_TOTAL, V_ACTIVE;
  logic [1:0]  MODE;
  logic        LOCKED, FRAME_DONE, TIMING_ERR;
  logic [23:0] FRAME_SUM;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0, n_done = 0, n_push = 0;
  int   cyc = 0, vfall_cyc = 0;

  vid_timing_rx #(
    .VGA_HT(V_HT), .VGA_HA(V_HA), .VGA_VT(V_VT), .VGA_VA(V_VA),
    .XGA_HT(X_HT), .XGA_HA(X_HA), .XGA_VT(X_VT), .XGA_VA(X_VA)
  ) dut (
    .DCLK(DCLK), .RST_X(RST_X),
    .VID_HSYNC_X(VID_HSYNC_X), .VID_VSYNC_X(VID_VSYNC_X), .VID_DE(VID_DE),
    .VID_R(VID_R), .VID_G(VID_G), .VID_B(VID_B),
    .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE),
    .MODE(MODE), .LOCKED(LOCKED), .FRAME_DONE(FRAME_DONE), .TIMING_ERR(TIMING_ERR),
    .FRAME_SUM(FRAME_SUM)
  );

  always #5 DCLK = ~DCLK;
  always @(posedge DCLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sum(input logic [23:0] rgb, input int n);
    longint p;
    logic   en;
    p = longint'(rgb) * n;
`ifdef VID_RX_SUM_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en ? {8'h0, p[23:0]} : 32'h0;
  endfunction

  task automatic push(input int ht, ha, vt, va, mode, lk, er, input logic [31:0] sum);
    exp_t e;
    e.ht = ht; e.ha = ha; e.vt = vt; e.va = va;
    e.mode = mode; e.lk = lk; e.er = er; e.sum = sum;
    sb.push_back(e);
    n_push++;
  endtask

  // VSYNC and HSYNC fall together at line 0 clock 0; active lines start at line 3, DE at clock 6.
  task automatic send_frame(input int ht, ha, vt, va, nlines, short_line, input logic [23:0] rgb);
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < ht; c++) begin
        @(posedge DCLK); #1;
        VID_HSYNC_X = !(c < 4);
        VID_VSYNC_X = !(l < 2);
        VID_DE = (l >= 3) && (l < 3 + va) && (c >= 6) && (c < 6 + ha) &&
                 !((l == short_line) && (c == 5 + ha));
        {VID_R, VID_G, VID_B} = VID_DE ? rgb : 24'($urandom);
        if (l == 0 && c == 0) vfall_cyc = cyc;
      end
    end
  endtask

  task automatic send_sat(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge DCLK); #1;
      VID_HSYNC_X = 1'b1;
      VID_VSYNC_X = !(i < 100);
      VID_DE = 1'b0;
      {VID_R, VID_G, VID_B} = 24'($urandom);
      if (i == 0) vfall_cyc = cyc;
    end
  endtask

  task automatic vga(input int short_line);
    send_frame(V_HT, V_HA, V_VT, V_VA, V_VT, short_line, V_RGB);
  endtask

  task automatic xga();
    send_frame(X_HT, X_HA, X_VT, X_VA, X_VT, -1, X_RGB);
  endtask

  always @(negedge DCLK) begin : mon
    exp_t e;
    if (FRAME_DONE) begin
      n_done++;
      chk("fd_latency", cyc - vfall_cyc, 2);
      chk("fd_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("h_total", H_TOTAL, e.ht);
        chk("h_active", H_ACTIVE, e.ha);
        chk("v_total", V_TOTAL, e.vt);
        chk("v_active", V_ACTIVE, e.va);
        chk("mode", MODE, e.mode);
        chk("locked", LOCKED, e.lk);
        chk("timing_err", TIMING_ERR, e.er);
        chk("frame_sum", FRAME_SUM, e.sum);
      end
    end
  end

  initial begin
    logic [31:0] vsum, xsum;
    vsum = exp_sum(V_RGB, V_HA * V_VA);
    xsum = exp_sum(X_RGB, X_HA * X_VA);
    RST_X = 1'b0;
    VID_HSYNC_X = 1'b1; VID_VSYNC_X = 1'b1; VID_DE = 1'b0;
    {VID_R, VID_G, VID_B} = 24'h0;
    repeat (3) @(posedge DCLK);
    #1;
    chk("rst_h_total", H_TOTAL, 0);
    chk("rst_h_active", H_ACTIVE, 0);
    chk("rst_v_total", V_TOTAL, 0);
    chk("rst_v_active", V_ACTIVE, 0);
    chk("rst_mode", MODE, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_frame_done", FRAME_DONE, 0);
    chk("rst_timing_err", TIMING_ERR, 0);
    chk("rst_frame_sum", FRAME_SUM, 0);
    @(posedge DCLK); #1;
    RST_X = 1'b1;
    repeat (5) @(posedge DCLK);

    // VGA lock, then a short active line while locked
    vga(-1);
    push(V_HT, V_HA, V_VT, V_VA, 1, 0, 0, vsum);                vga(-1);
    push(V_HT, V_HA, V_VT, V_VA, 1, 1, 0, vsum);                vga(-1);
    push(V_HT, V_HA, V_VT, V_VA, 1, 1, 0, vsum);                vga(10);
    push(V_HT, V_HA, V_VT, V_VA, 0, 0, 1, vsum - exp_sum(V_RGB, 1)); vga(-1);
    push(V_HT, V_HA, V_VT, V_VA, 1, 0, 1, vsum);                vga(-1);
    // switch to XGA
    push(V_HT, V_HA, V_VT, V_VA, 1, 1, 1, vsum);                xga();
    push(X_HT, X_HA, X_VT, X_VA, 2, 0, 1, xsum);                xga();
    push(X_HT, X_HA, X_VT, X_VA, 2, 1, 1, xsum);                send_sat(4200);
    // HSYNC held high: horizontal counter saturates
    push(4095, 0, 0, 0, 0, 0, 1, 32'h0);                        vga(-1);
    push(V_HT, V_HA, V_VT, V_VA, 1, 0, 1, vsum);                vga(-1);
    push(V_HT, V_HA, V_VT, V_VA, 1, 1, 1, vsum);
    send_frame(V_HT, V_HA, V_VT, V_VA, 5, -1, V_RGB);
    chk("pre_rst_locked", LOCKED, 1);
    chk("pre_rst_terr", TIMING_ERR, 1);

    // reset mid-frame while locked
    RST_X = 1'b0;
    #1;
    chk("mid_rst_h_total", H_TOTAL, 0);
    chk("mid_rst_v_total", V_TOTAL, 0);
    chk("mid_rst_mode", MODE, 0);
    chk("mid_rst_locked", LOCKED, 0);
    chk("mid_rst_terr", TIMING_ERR, 0);
    chk("mid_rst_sum", FRAME_SUM, 0);
    VID_HSYNC_X = 1'b1; VID_VSYNC_X = 1'b1; VID_DE = 1'b0;
    repeat (3) @(posedge DCLK);
    #1;
    RST_X = 1'b1;
    repeat (5) @(posedge DCLK);
    vga(-1);
    push(V_HT, V_HA, V_VT, V_VA, 1, 0, 0, vsum);                vga(-1);
    push(V_HT, V_HA, V_VT, V_VA, 1, 1, 0, vsum);                vga(-1);
    repeat (10) @(posedge DCLK);
    #1;
    chk("done_count", n_done, n_push);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
